split_select_sequencer: RTL and testbench
=========================================

# split_select_sequencer

Clocked controller that generates the select-token stream for the PE's three-way split, so the split can route filter, ifmap and partial-sum packets without a testbench-style random select source. For each pass it issues select code 0 `cfg_n0` times, then code 1 `cfg_n1` times, then code 2 `cfg_n2` times, and repeats for `cfg_passes` passes. Tokens leave on a 4-phase bundled-data req/ack channel that matches the split's `S` channel (P4PhaseBD, width 2). The ack input is synchronized internally.

## Interface
- `CNT_W`, 8: width of per-phase token counts.
- `PASS_W`, 8: width of the pass count.
- `SYNC_STAGES`, 2: flops in the ack synchronizer; must be 2 or more.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
- `cfg_n0`  in  CNT_W  number of code-0 (filter) tokens per pass.
- `cfg_n1`  in  CNT_W  number of code-1 (ifmap) tokens per pass.
- `cfg_n2`  in  CNT_W  number of code-2 (psum) tokens per pass.
- `cfg_passes`  in  PASS_W  number of passes.
- `s_req`  out  1  4-phase request to the split's select channel.
- `s_data`  out  2  select code; valid while `s_req`=1 and until `s_ack` falls.
- `s_ack`  in  1  4-phase acknowledge; asynchronous to `clk`.
- `busy`  out  1  high from the accepted start until completion.
- `done`  out  1  one-cycle pulse when the sequence completes.

## Operation
- Reset values: `s_req`=0, `s_data`=0, `busy`=0, `done`=0, state IDLE, all counters 0, synchronizer flops 0.
- The states are IDLE, REQ_UP, REQ_DOWN and FINISH.
- **IDLE**
  - On `start`=1, latch all four cfg inputs and set `busy`=1.
  - Select the first phase with a nonzero count, in order 0, 1, 2.
  - If `cfg_passes`=0 or all three counts are 0, go to FINISH. Otherwise load `s_data` and go to REQ_UP.
- **REQ_UP**: drive `s_req`=1 with `s_data` held. When the synchronized ack is 1, clear `s_req` and go to REQ_DOWN.
- **REQ_DOWN**
  - `s_data` stays held. Wait for the synchronized ack to be 0, then advance the counters.
  - Increment the token count. When it reaches the count for the current phase, move to the next phase with a nonzero count.
  - After phase 2, or when no later phase has a nonzero count, increment the pass count and restart at the first phase with a nonzero count.
  - When the pass count reaches `cfg_passes`, go to FINISH. Otherwise load the next code and go to REQ_UP.
- **FINISH**: pulse `done`=1 for one cycle, clear `busy`, return to IDLE.
- `start` while `busy`=1 is ignored; the latched config is unaffected.
- Changes on cfg inputs after the start cycle have no effect.
- Counters are compared with equality, so no wrap-around occurs. Maximum run length is (2^CNT_W−1)·3·(2^PASS_W−1) tokens.
- Reset mid-operation:
  - `s_req` drops to 0 and the block goes to IDLE on that edge; no `done` is issued.
  - The environment must return `s_ack` to 0 before the next start.

## Timing
- Start accepted on edge E:
  - `busy`=1 and `s_req`=1 (first token) after E.
  - For an empty config, `busy`=1 after E and `done`=1 for the cycle after E+1.
- The ack synchronizer adds SYNC_STAGES cycles.
- `s_req` falls on the (SYNC_STAGES+1)-th rising edge after `s_ack` rises.
- The next `s_req` rises on the (SYNC_STAGES+1)-th edge after `s_ack` falls.
- Minimum token period with a zero-delay environment: 2·(SYNC_STAGES+1) cycles, i.e. 6.
- `done` is asserted on the edge after the final ack-low is seen; `busy` falls on the following edge.
- `s_data` changes only in cycles where `s_req`=0 and the synchronized ack is 0, which meets bundled-data setup.

## Structure
- Package `split_seq_pkg` holds:
  - the state enum;
  - code constants `SEL_FILTER`=2'd0, `SEL_IFMAP`=2'd1, `SEL_PSUM`=2'd2;
  - a next-nonzero-phase function.
- Sub-module `ack_sync`: a parameterized flop chain of SYNC_STAGES flops with synchronous reset.
- The top level holds the FSM, the token, phase and pass counters, and the latched config registers.

## Test plan
- **Reset**: hold `reset` for 3 cycles with `s_ack`=0 → `s_req`, `s_data`, `busy` and `done` are all 0. With no start, `s_req` stays 0 for 20 cycles.
- **Single pass**: n0=2, n1=1, n2=1, passes=1, immediate ack → codes 0, 0, 1, 2 in that order, 6-cycle spacing, exactly one `done` pulse, `busy` then 0.
- **Zero-phase skip and multi-pass**: n0=0, n1=2, n2=0, passes=3 → six tokens, all code 1; no code 0 or 2 ever issued.
- **Empty config**: n0=n1=n2=0, passes=5 → no `s_req`; `done` pulses 2 cycles after start. Repeat with passes=0 → same result.
- **Slow ack and ignored start**:
  - ack delayed 10 cycles → `s_req` and `s_data` are held stable until ack is seen.
  - `start` pulsed mid-run with different cfg → ignored; the sequence matches the original cfg.
- **Reset during REQ_UP** of the 2nd token → `s_req`=0 after the reset edge; no `done`. Release ack, then a new start with n0=1, passes=1 → a single code-0 token and `done`.

Source files
------------

// File: rtl/split_seq_pkg.sv
// split_seq_pkg: shared states, select codes and phase search for the split select sequencer
package split_seq_pkg;
    typedef enum logic [1:0] {IDLE, REQ_UP, REQ_DOWN, FINISH} state_e;
    localparam logic [1:0] SEL_FILTER = 2'd0;
    localparam logic [1:0] SEL_IFMAP  = 2'd1;
    localparam logic [1:0] SEL_PSUM   = 2'd2;
    // {found, phase}: lowest phase >= from whose count is nonzero
    function automatic logic [2:0] next_phase(input logic [1:0] from, input logic [2:0] nz);
        next_phase = 3'b000;
        for (int i = 2; i >= 0; i--)
            if (nz[i] && 2'(i) >= from) next_phase = {1'b1, 2'(i)};
    endfunction
endpackage

// File: rtl/ack_sync.sv
// ack_sync: flop chain bringing the asynchronous acknowledge into the clk domain
module ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a_i,
    output logic y_o
);
    logic [STAGES-1:0] sync_q;
    always_ff @(posedge clk)
        sync_q <= reset ? '0 : {sync_q[STAGES-2:0], a_i};
    assign y_o = sync_q[STAGES-1];
endmodule

// File: rtl/split_select_sequencer.sv
// split_select_sequencer: issues per-pass runs of select codes 0,1,2 on a 4-phase req/ack channel
module split_select_sequencer
    import split_seq_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int PASS_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_n0,
    input  logic [CNT_W-1:0]  cfg_n1,
    input  logic [CNT_W-1:0]  cfg_n2,
    input  logic [PASS_W-1:0] cfg_passes,
    output logic              s_req,
    output logic [1:0]        s_data,
    input  logic              s_ack,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] CODE [3] = '{SEL_FILTER, SEL_IFMAP, SEL_PSUM};
    state_e            state_q;
    logic              s_req_q, busy_q, done_q, ack_s, tok_wrap;
    logic [1:0]        s_data_q, phase_q, first_q, phase_d;
    logic [2:0]        nz_in, nz, first_in, adv;
    logic [CNT_W-1:0]  cnt_q [3];
    logic [CNT_W-1:0]  tok_q, tok_d;
    logic [PASS_W-1:0] passes_q, pass_q, pass_d;
    ack_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .reset(reset), .a_i(s_ack), .y_o(ack_s));
    always_comb begin
        nz_in    = {|cfg_n2, |cfg_n1, |cfg_n0};
        nz       = {|cnt_q[2], |cnt_q[1], |cnt_q[0]};
        first_in = next_phase(2'd0, nz_in);
        tok_d    = tok_q + CNT_W'(1);
        tok_wrap = tok_d == cnt_q[phase_q];
        adv      = tok_wrap ? next_phase(phase_q + 2'd1, nz) : {1'b1, phase_q};
        phase_d  = adv[2] ? adv[1:0] : first_q;
        pass_d   = adv[2] ? pass_q : pass_q + PASS_W'(1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            s_req_q  <= 1'b0;
            s_data_q <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tok_q    <= '0;
            pass_q   <= '0;
            phase_q  <= 2'd0;
            first_q  <= 2'd0;
            cnt_q    <= '{default: '0};
            passes_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    // busy is still high in the cycle after FINISH, so a start there is ignored
                    if (start && !busy_q) begin
                        cnt_q    <= '{cfg_n0, cfg_n1, cfg_n2};
                        passes_q <= cfg_passes;
                        busy_q   <= 1'b1;
                        tok_q    <= '0;
                        pass_q   <= '0;
                        phase_q  <= first_in[1:0];
                        first_q  <= first_in[1:0];
                        if (cfg_passes == '0 || !first_in[2]) state_q <= FINISH;
                        else begin
                            s_data_q <= CODE[first_in[1:0]];
                            s_req_q  <= 1'b1;
                            state_q  <= REQ_UP;
                        end
                    end
                end
                REQ_UP: if (ack_s) begin
                    s_req_q <= 1'b0;
                    state_q <= REQ_DOWN;
                end
                REQ_DOWN: if (!ack_s) begin
                    tok_q   <= tok_wrap ? '0 : tok_d;
                    phase_q <= phase_d;
                    pass_q  <= pass_d;
                    if (pass_d == passes_q) state_q <= FINISH;
                    else begin
                        s_data_q <= CODE[phase_d];
                        s_req_q  <= 1'b1;
                        state_q  <= REQ_UP;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign s_req  = s_req_q;
    assign s_data = s_data_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_split_select_sequencer.sv
// tb_split_select_sequencer: table-driven and hand-sequenced checks with a code scoreboard
module tb_split_select_sequencer;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, s_ack = 1'b0;
    logic [7:0] cfg_n0 = '0, cfg_n1 = '0, cfg_n2 = '0, cfg_passes = '0;
    logic       s_req, busy, done;
    logic [1:0] s_data;

    split_select_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_n0(cfg_n0), .cfg_n1(cfg_n1), .cfg_n2(cfg_n2), .cfg_passes(cfg_passes),
        .s_req(s_req), .s_data(s_data), .s_ack(s_ack), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int cyc = 0, last_rise = -1, tokens = 0, done_cnt = 0, extra_tok = 0, hold_viol = 0;
    int ack_dly = 0;
    bit gap_en = 1'b0;
    logic req_prev = 1'b0, hold_prev = 1'b0;
    logic [1:0] data_prev = 2'd0, e;
    logic [1:0] exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // environment: raise ack ack_dly cycles after req, drop it as soon as req drops
    always begin
        wait (s_req === 1'b1);
        repeat (ack_dly) @(negedge clk);
        s_ack = 1'b1;
        wait (s_req === 1'b0);
        s_ack = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        if (s_req && !req_prev) begin
            tokens++;
            if (gap_en && last_rise >= 0) chk("token_gap", cyc - last_rise, 6);
            last_rise = cyc;
            if (exp_q.size() == 0) extra_tok++;
            else begin
                e = exp_q.pop_front();
                chk("code", int'(s_data), int'(e));
            end
        end
        if (hold_prev && s_data !== data_prev) hold_viol++;
        if (done) done_cnt++;
        hold_prev = s_req || s_ack;
        data_prev = s_data;
        req_prev  = s_req;
    end

    task automatic push_exp(input logic [7:0] a, b, c, p);
        for (int k = 0; k < int'(p); k++) begin
            for (int i = 0; i < int'(a); i++) exp_q.push_back(2'd0);
            for (int i = 0; i < int'(b); i++) exp_q.push_back(2'd1);
            for (int i = 0; i < int'(c); i++) exp_q.push_back(2'd2);
        end
    endtask

    task automatic clear_counts();
        tokens = 0; done_cnt = 0; extra_tok = 0; hold_viol = 0; last_rise = -1;
    endtask

    task automatic pulse_start(input logic [7:0] a, b, c, p);
        @(negedge clk);
        cfg_n0 = a; cfg_n1 = b; cfg_n2 = c; cfg_passes = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic finish_checks(input int exp_tok);
        chk("token_count", tokens, exp_tok);
        chk("queue_drained", exp_q.size(), 0);
        chk("extra_tokens", extra_tok, 0);
        chk("data_hold", hold_viol, 0);
    endtask

    typedef struct {
        logic [7:0] n0, n1, n2, passes;
        int dly, exp_tok;
        bit gap;
    } vec_t;
    vec_t v[6];

    initial begin
        v[0] = '{8'd2, 8'd1, 8'd0 + 8'd1, 8'd1, 0, 4, 1'b1};
        v[1] = '{8'd0, 8'd2, 8'd0, 8'd3, 0, 6, 1'b1};
        v[2] = '{8'd1, 8'd0, 8'd3, 8'd2, 2, 8, 1'b0};
        v[3] = '{8'd3, 8'd3, 8'd3, 8'd1, 1, 9, 1'b0};
        v[4] = '{8'd0, 8'd0, 8'd0, 8'd5, 0, 0, 1'b0};
        v[5] = '{8'd0, 8'd0, 8'd2, 8'd0, 0, 0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_s_req", int'(s_req), 0);
        chk("reset_s_data", int'(s_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset = 1'b0;
        clear_counts();
        repeat (20) @(negedge clk);
        chk("idle_no_tokens", tokens, 0);

        for (int i = 0; i < 6; i++) begin
            clear_counts();
            ack_dly = v[i].dly;
            gap_en = v[i].gap;
            push_exp(v[i].n0, v[i].n1, v[i].n2, v[i].passes);
            pulse_start(v[i].n0, v[i].n1, v[i].n2, v[i].passes);
            wait_done(v[i].exp_tok * 40 + 50);
            finish_checks(v[i].exp_tok);
            gap_en = 1'b0;
        end

        for (int k = 0; k < 2; k++) begin
            clear_counts();
            @(negedge clk);
            cfg_n0 = 0; cfg_n1 = 0; cfg_n2 = 0; cfg_passes = k == 0 ? 8'd5 : 8'd0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("empty_busy_e", int'(busy), 1);
            chk("empty_done_e", int'(done), 0);
            @(negedge clk);
            chk("empty_done_e1", int'(done), 1);
            @(negedge clk);
            chk("empty_done_off", int'(done), 0);
            chk("empty_busy_off", int'(busy), 0);
            chk("empty_no_req", tokens, 0);
        end

        clear_counts();
        ack_dly = 10;
        push_exp(8'd1, 8'd1, 8'd1, 8'd2);
        pulse_start(8'd1, 8'd1, 8'd1, 8'd2);
        repeat (6) @(negedge clk);
        chk("slow_req_held", int'(s_req), 1);
        chk("slow_data_held", int'(s_data), 0);
        pulse_start(8'd5, 8'd5, 8'd5, 8'd5);
        cfg_n0 = 8'd7; cfg_n1 = 8'd7; cfg_n2 = 8'd7; cfg_passes = 8'd7;
        wait_done(600);
        finish_checks(6);

        clear_counts();
        ack_dly = 10;
        push_exp(8'd3, 8'd0, 8'd0, 8'd1);
        pulse_start(8'd3, 8'd0, 8'd0, 8'd1);
        for (int i = 0; i < 200 && tokens < 2; i++) @(negedge clk);
        chk("reach_2nd_token", tokens, 2);
        chk("second_req_up", int'(s_req), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_drops_req", int'(s_req), 0);
        repeat (20) @(negedge clk);
        chk("reset_no_done", done_cnt, 0);
        chk("reset_busy_low", int'(busy), 0);
        chk("reset_left_one", exp_q.size(), 1);
        exp_q.delete();
        clear_counts();
        ack_dly = 0;
        push_exp(8'd1, 8'd0, 8'd0, 8'd1);
        pulse_start(8'd1, 8'd0, 8'd0, 8'd1);
        wait_done(100);
        finish_checks(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
